ccip_c0_rr_credit_arbiter: RTL and testbench

//  Single-clock scheduler sharing the CCI-P c0 (read) channel among NUM_INSTANCES accelerator instances.

---
 rtl/ccip_c0_rr_credit_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ccip_c0_rr_credit_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_rr_credit_arbiter.sv
// Round-robin scheduler for the CCI-P c0 read channel. Reads are tagged with the instance ID in mdata[15:14],
// reads in flight are capped per instance, and responses are routed back to their owner by tag.
module ccip_c0_rr_credit_arbiter #(
    parameter int NUM_INSTANCES   = 2,
    parameter int ADDR_W          = 42,
    parameter int MAX_OUTSTANDING = 64,
    parameter int DATA_W          = 512
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INSTANCES-1:0]        req_valid,
    input  logic [NUM_INSTANCES*ADDR_W-1:0] req_addr,
    input  logic [NUM_INSTANCES*14-1:0]     req_mdata,
    output logic [NUM_INSTANCES-1:0]        req_ready,
    output logic                            tx_valid,
    output logic [ADDR_W-1:0]               tx_addr,
    output logic [15:0]                     tx_mdata,
    input  logic                            tx_almfull,
    input  logic                            rsp_valid,
    input  logic [15:0]                     rsp_mdata,
    input  logic [DATA_W-1:0]               rsp_data,
    output logic [NUM_INSTANCES-1:0]        inst_rsp_valid,
    output logic [13:0]                     inst_rsp_mdata,
    output logic [DATA_W-1:0]               inst_rsp_data,
    output logic [NUM_INSTANCES*11-1:0]     outstanding,
    output logic [NUM_INSTANCES-1:0]        err_unexpected,
    output logic                            idle
);

    if (NUM_INSTANCES < 1 || NUM_INSTANCES > 4) begin : g_bad_num_instances
        $error("NUM_INSTANCES must be 1..4 to fit the 2-bit tag");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 1024) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be 1..1024 to fit the 11-bit counters");
    end

    localparam logic [10:0] MAX_CNT  = 11'(MAX_OUTSTANDING);
    localparam logic [1:0]  LAST_RST = 2'(NUM_INSTANCES - 1);

    logic                     tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]        tx_addr_q, tx_addr_d;
    logic [15:0]              tx_mdata_q, tx_mdata_d;
    logic [1:0]               last_q, last_d;
    logic [10:0]              cnt_q [NUM_INSTANCES];
    logic [10:0]              cnt_d [NUM_INSTANCES];
    logic [NUM_INSTANCES-1:0] err_q, err_d;
    logic [NUM_INSTANCES-1:0] rsp_valid_q, rsp_valid_d;
    logic [13:0]              rsp_mdata_q, rsp_mdata_d;
    logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
    logic                     idle_q, idle_d;

    logic [3:0]               elig;
    logic                     grant_found;
    logic [1:0]               grant_idx;
    logic                     issue;
    logic [ADDR_W-1:0]        sel_addr;
    logic [13:0]              sel_mdata;
    logic [1:0]               rsp_tag;
    logic                     rsp_hit;

    // Eligibility is padded to four bits so the scan can always index it with a 2-bit pointer.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < MAX_CNT);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_INSTANCES; k++) begin
            if (!grant_found && elig[2'((int'(last_q) + k) % NUM_INSTANCES)]) begin
                grant_found = 1'b1;
                grant_idx   = 2'((int'(last_q) + k) % NUM_INSTANCES);
            end
        end
    end

    // Handshake: a request transfers on the cycle req_valid[i] && req_ready[i]. At most one ready bit is high,
    // and it only rises for an instance that is already valid, so a grant is always an issue.
    assign issue = grant_found && !tx_almfull && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            req_ready[i] = issue && (grant_idx == 2'(i));
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_mdata = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_mdata = req_mdata[i*14 +: 14];
            end
        end
    end

    always_comb begin
        tx_valid_d = issue;
        tx_addr_d  = issue ? sel_addr : tx_addr_q;
        tx_mdata_d = issue ? {grant_idx, sel_mdata} : tx_mdata_q;
        last_d     = issue ? grant_idx : last_q;
    end

    // Tags beyond the instance count are dropped without touching any counter.
    assign rsp_tag = rsp_mdata[15:14];
    assign rsp_hit = rsp_valid && !reset && (int'(rsp_tag) < NUM_INSTANCES);

    always_comb begin
        rsp_valid_d = '0;
        rsp_mdata_d = rsp_hit ? rsp_mdata[13:0] : rsp_mdata_q;
        rsp_data_d  = rsp_hit ? rsp_data : rsp_data_q;
        err_d       = err_q;
        idle_d      = !tx_valid_d;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            cnt_d[i]       = cnt_q[i];
            rsp_valid_d[i] = rsp_hit && (rsp_tag == 2'(i));
            if (rsp_valid_d[i] && cnt_q[i] == 11'd0) begin
                err_d[i] = 1'b1;
            end
            if (req_ready[i] && !(rsp_valid_d[i] && cnt_q[i] != 11'd0)) begin
                cnt_d[i] = cnt_q[i] + 11'd1;
            end else if (!req_ready[i] && rsp_valid_d[i] && cnt_q[i] != 11'd0) begin
                cnt_d[i] = cnt_q[i] - 11'd1;
            end
            if (cnt_d[i] != 11'd0) begin
                idle_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            last_q      <= LAST_RST;
            err_q       <= '0;
            rsp_valid_q <= '0;
            rsp_mdata_q <= '0;
            rsp_data_q  <= '0;
            // Reset leaves nothing in flight, so idle already holds.
            idle_q      <= 1'b1;
            for (int i = 0; i < NUM_INSTANCES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            last_q      <= last_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mdata_q <= rsp_mdata_d;
            rsp_data_q  <= rsp_data_d;
            idle_q      <= idle_d;
            for (int i = 0; i < NUM_INSTANCES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            outstanding[i*11 +: 11] = cnt_q[i];
        end
    end

    assign tx_valid       = tx_valid_q;
    assign tx_addr        = tx_addr_q;
    assign tx_mdata       = tx_mdata_q;
    assign inst_rsp_valid = rsp_valid_q;
    assign inst_rsp_mdata = rsp_mdata_q;
    assign inst_rsp_data  = rsp_data_q;
    assign err_unexpected = err_q;
    assign idle           = idle_q;

endmodule

// File: tb/tb_ccip_c0_rr_credit_arbiter.sv
// Directed bench for the c0 round-robin credit arbiter: a per-cycle vector table plus reset sequences.
module tb_ccip_c0_rr_credit_arbiter;

    localparam int N      = 2;
    localparam int ADDR_W = 42;
    localparam int MAXO   = 4;
    localparam int DATA_W = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*ADDR_W-1:0]  req_addr;
    logic [N*14-1:0]      req_mdata;
    logic [N-1:0]         req_ready;
    logic                 tx_valid;
    logic [ADDR_W-1:0]    tx_addr;
    logic [15:0]          tx_mdata;
    logic                 tx_almfull = 1'b0;
    logic                 rsp_valid = 1'b0;
    logic [15:0]          rsp_mdata = '0;
    logic [DATA_W-1:0]    rsp_data = '0;
    logic [N-1:0]         inst_rsp_valid;
    logic [13:0]          inst_rsp_mdata;
    logic [DATA_W-1:0]    inst_rsp_data;
    logic [N*11-1:0]      outstanding;
    logic [N-1:0]         err_unexpected;
    logic                 idle;

    ccip_c0_rr_credit_arbiter #(
        .NUM_INSTANCES  (N),
        .ADDR_W         (ADDR_W),
        .MAX_OUTSTANDING(MAXO),
        .DATA_W         (DATA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_mdata     (req_mdata),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_addr       (tx_addr),
        .tx_mdata      (tx_mdata),
        .tx_almfull    (tx_almfull),
        .rsp_valid     (rsp_valid),
        .rsp_mdata     (rsp_mdata),
        .rsp_data      (rsp_data),
        .inst_rsp_valid(inst_rsp_valid),
        .inst_rsp_mdata(inst_rsp_mdata),
        .inst_rsp_data (inst_rsp_data),
        .outstanding   (outstanding),
        .err_unexpected(err_unexpected),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic        af;
        logic        rspv;
        logic [15:0] rmd;
        logic [1:0]  exp_rdy;
        logic        exp_txv;
        logic [1:0]  exp_tag;
        logic [10:0] exp_o0;
        logic [10:0] exp_o1;
        logic [1:0]  exp_irv;
        logic [1:0]  exp_err;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic [1:0] rv, input logic af, input logic rspv, input logic [15:0] rmd,
                                input logic [1:0] rdy, input logic txv, input logic [1:0] tag,
                                input int o0, input int o1, input logic [1:0] irv, input logic [1:0] err,
                                input logic idl);
        vec_t v;
        v.rv = rv; v.af = af; v.rspv = rspv; v.rmd = rmd;
        v.exp_rdy = rdy; v.exp_txv = txv; v.exp_tag = tag;
        v.exp_o0 = 11'(o0); v.exp_o1 = 11'(o1);
        v.exp_irv = irv; v.exp_err = err; v.exp_idle = idl;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 42'h1000 + 42'(i);
            req_mdata[i*14 +: 14]        = 14'h100 + 14'(i);
        end

        // Both valid: alternate 0,1,0,1.
        add(2'b11, 0, 0, 16'h0,    2'b01, 1, 2'd0, 1, 0, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b10, 1, 2'd1, 1, 1, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b01, 1, 2'd0, 2, 1, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b10, 1, 2'd1, 2, 2, 2'b00, 2'b00, 0);
        // Almost-full for 10 cycles blocks all grants.
        for (int k = 0; k < 10; k++)
            add(2'b11, 1, 0, 16'h0, 2'b00, 0, 2'd0, 2, 2, 2'b00, 2'b00, 0);
        // Resumes from last+1 = 0.
        add(2'b11, 0, 0, 16'h0,    2'b01, 1, 2'd0, 3, 2, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b10, 1, 2'd1, 3, 3, 2'b00, 2'b00, 0);
        add(2'b00, 0, 1, 16'h4005, 2'b00, 0, 2'd0, 3, 2, 2'b10, 2'b00, 0);
        // Issue and tag-0 response in the same cycle: counter net unchanged.
        add(2'b01, 0, 1, 16'h0007, 2'b01, 1, 2'd0, 3, 2, 2'b01, 2'b00, 0);
        // Instance 1 alone up to the cap.
        add(2'b10, 0, 0, 16'h0,    2'b10, 1, 2'd1, 3, 3, 2'b00, 2'b00, 0);
        add(2'b10, 0, 0, 16'h0,    2'b10, 1, 2'd1, 3, 4, 2'b00, 2'b00, 0);
        add(2'b10, 0, 0, 16'h0,    2'b00, 0, 2'd0, 3, 4, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b01, 1, 2'd0, 4, 4, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 16'h0,    2'b00, 0, 2'd0, 4, 4, 2'b00, 2'b00, 0);
        add(2'b10, 0, 1, 16'h4001, 2'b00, 0, 2'd0, 4, 3, 2'b10, 2'b00, 0);
        add(2'b10, 0, 0, 16'h0,    2'b10, 1, 2'd1, 4, 4, 2'b00, 2'b00, 0);
        // Drain instance 0, then an unexpected response and a dropped tag.
        for (int k = 0; k < 4; k++)
            add(2'b00, 0, 1, 16'h0010 + 16'(k), 2'b00, 0, 2'd0, 3 - k, 4, 2'b01, 2'b00, 0);
        add(2'b00, 0, 1, 16'h0009, 2'b00, 0, 2'd0, 0, 4, 2'b01, 2'b01, 0);
        add(2'b00, 0, 1, 16'h8003, 2'b00, 0, 2'd0, 0, 4, 2'b00, 2'b01, 0);
        for (int k = 0; k < 4; k++)
            add(2'b00, 0, 1, 16'h4020 + 16'(k), 2'b00, 0, 2'd0, 0, 3 - k, 2'b10, 2'b01, (k == 3));
        add(2'b00, 0, 0, 16'h0,    2'b00, 0, 2'd0, 0, 0, 2'b00, 2'b01, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_tx_valid", 64'(tx_valid), 64'h0);
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_err", 64'(err_unexpected), 64'h0);
        chk("rst_inst_rsp_valid", 64'(inst_rsp_valid), 64'h0);
        chk("rst_idle", 64'(idle), 64'h1);
        reset = 1'b0;

        foreach (vecs[r]) begin
            req_valid  = vecs[r].rv;
            tx_almfull = vecs[r].af;
            rsp_valid  = vecs[r].rspv;
            rsp_mdata  = vecs[r].rmd;
            rsp_data   = 64'hD000 + 64'(r);
            #1;
            chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_rdy));
            tick();
            chk($sformatf("row%0d_tx_valid", r), 64'(tx_valid), 64'(vecs[r].exp_txv));
            if (vecs[r].exp_txv) begin
                chk($sformatf("row%0d_tx_tag", r), 64'(tx_mdata[15:14]), 64'(vecs[r].exp_tag));
                chk($sformatf("row%0d_tx_mdata", r), 64'(tx_mdata[13:0]), 64'(14'h100 + 14'(vecs[r].exp_tag)));
                chk($sformatf("row%0d_tx_addr", r), 64'(tx_addr), 64'(42'h1000 + 42'(vecs[r].exp_tag)));
            end
            chk($sformatf("row%0d_out0", r), 64'(outstanding[10:0]), 64'(vecs[r].exp_o0));
            chk($sformatf("row%0d_out1", r), 64'(outstanding[21:11]), 64'(vecs[r].exp_o1));
            chk($sformatf("row%0d_rsp_valid", r), 64'(inst_rsp_valid), 64'(vecs[r].exp_irv));
            chk($sformatf("row%0d_err", r), 64'(err_unexpected), 64'(vecs[r].exp_err));
            chk($sformatf("row%0d_idle", r), 64'(idle), 64'(vecs[r].exp_idle));
            if (vecs[r].exp_irv != 2'b00) begin
                chk($sformatf("row%0d_rsp_mdata", r), 64'(inst_rsp_mdata), 64'(vecs[r].rmd[13:0]));
                chk($sformatf("row%0d_rsp_data", r), 64'(inst_rsp_data), 64'hD000 + 64'(r));
            end
        end

        // Build counts 3/2, then reset mid-operation with a response arriving.
        rsp_valid = 1'b0;
        req_valid = 2'b11;
        repeat (5) tick();
        req_valid = 2'b00;
        chk("pre_reset_out0", 64'(outstanding[10:0]), 64'd3);
        chk("pre_reset_out1", 64'(outstanding[21:11]), 64'd2);
        reset     = 1'b1;
        req_valid = 2'b11;
        rsp_valid = 1'b1;
        rsp_mdata = 16'h0001;
        #1;
        chk("in_reset_ready", 64'(req_ready), 64'h0);
        tick();
        chk("mid_reset_outstanding", 64'(outstanding), 64'h0);
        chk("mid_reset_idle", 64'(idle), 64'h1);
        chk("mid_reset_tx_valid", 64'(tx_valid), 64'h0);
        chk("mid_reset_rsp_valid", 64'(inst_rsp_valid), 64'h0);
        chk("mid_reset_err", 64'(err_unexpected), 64'h0);

        // A stale response after reset is delivered and flagged.
        reset     = 1'b0;
        req_valid = 2'b00;
        rsp_mdata = 16'h0002;
        tick();
        rsp_valid = 1'b0;
        chk("stale_rsp_valid", 64'(inst_rsp_valid), 64'h1);
        chk("stale_err", 64'(err_unexpected), 64'h1);
        chk("stale_out0", 64'(outstanding[10:0]), 64'h0);

        // Priority restarts at instance 0 after reset.
        req_valid = 2'b11;
        #1;
        chk("post_reset_priority", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
